// File: rtl/spi_master.sv
// SPI initiator for the 40-bit register-port protocol (1 rd + 7 addr + 32 data).
// Mode 0, MSB first, one CSL-framed transfer per accepted start pulse.
module spi_master #(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        rd,
    input  logic [6:0]  addr,
    input  logic [31:0] wdat,
    output logic [31:0] rdat,
    output logic        busy,
    output logic        done,
    output logic        spi_csl,
    output logic        spi_sclk,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    // state | meaning
    // IDLE  | waiting for start, CSL high, SCLK low
    // SHIFT | 40 SCLK periods; sample MISO on rise, launch MOSI on fall
    // HOLD  | one half-period with CSL still low after the last fall
    // GAP   | one half-period of CSL high before start is accepted again
    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [HW-1:0] HALF_MAX = HW'(CLK_DIV - 1);
    localparam logic [5:0]    LAST_BIT = 6'd39;

    state_t         state, state_nxt;
    logic [HW-1:0]  half_cnt, half_nxt;
    logic [5:0]     bit_cnt, bit_nxt;
    logic [39:0]    shift, shift_nxt;
    logic           rd_q, rd_nxt;
    logic           sclk_nxt, csl_nxt, mosi_nxt, busy_nxt, done_nxt;
    logic [31:0]    rdat_nxt;
    logic           half_end;

    assign half_end = (half_cnt == HALF_MAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            half_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            rd_q     <= 1'b0;
            spi_sclk <= 1'b0;
            spi_csl  <= 1'b1;
            spi_mosi <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rdat     <= '0;
        end else begin
            state    <= state_nxt;
            half_cnt <= half_nxt;
            bit_cnt  <= bit_nxt;
            shift    <= shift_nxt;
            rd_q     <= rd_nxt;
            spi_sclk <= sclk_nxt;
            spi_csl  <= csl_nxt;
            spi_mosi <= mosi_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            rdat     <= rdat_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        half_nxt  = half_cnt;
        bit_nxt   = bit_cnt;
        shift_nxt = shift;
        rd_nxt    = rd_q;
        sclk_nxt  = spi_sclk;
        csl_nxt   = spi_csl;
        mosi_nxt  = spi_mosi;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        rdat_nxt  = rdat;

        case (state)
            IDLE: begin
                if (start) begin
                    // Read frames carry zeros in the data field.
                    shift_nxt = {rd, addr, (rd ? 32'h0 : wdat)};
                    rd_nxt    = rd;
                    mosi_nxt  = rd;
                    csl_nxt   = 1'b0;
                    sclk_nxt  = 1'b0;
                    busy_nxt  = 1'b1;
                    half_nxt  = '0;
                    bit_nxt   = '0;
                    state_nxt = SHIFT;
                end
            end

            SHIFT: begin
                if (half_end) begin
                    half_nxt = '0;
                    if (!spi_sclk) begin
                        sclk_nxt  = 1'b1;
                        shift_nxt = {shift[38:0], spi_miso};
                    end else begin
                        sclk_nxt = 1'b0;
                        if (bit_cnt == LAST_BIT) begin
                            mosi_nxt  = 1'b0;
                            state_nxt = HOLD;
                        end else begin
                            mosi_nxt = shift[39];
                            bit_nxt  = bit_cnt + 6'd1;
                        end
                    end
                end else begin
                    half_nxt = half_cnt + 1'b1;
                end
            end

            HOLD: begin
                if (half_end) begin
                    half_nxt  = '0;
                    csl_nxt   = 1'b1;
                    done_nxt  = 1'b1;
                    state_nxt = GAP;
                    if (rd_q) begin
                        rdat_nxt = shift[31:0];
                    end
                end else begin
                    half_nxt = half_cnt + 1'b1;
                end
            end

            GAP: begin
                if (half_end) begin
                    half_nxt  = '0;
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end else begin
                    half_nxt = half_cnt + 1'b1;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
